// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared definitions for the MEM-stage data-memory responder.
//   state_e          responder FSM states (idle / access in flight / completion)
//   WordWidth        data word width
//   DefaultLatency   default access latency in cycles (legal 1..15)
//   DefaultDepthLog2 default log2 of backing-array depth in words
package mem_resp_pkg;

    localparam int unsigned WordWidth        = 16;
    localparam int unsigned DefaultLatency   = 4;
    localparam int unsigned DefaultDepthLog2 = 10;
    localparam int unsigned CntWidth         = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/mem_array.sv
// mem_array: synchronous single-port RAM, 2**DEPTH_LOG2 x WordWidth.
//   clk    rising-edge clock
//   rst_n  async active-low reset (read register only; contents are not reset)
//   we     write enable, commits wdata to addr at the clock edge
//   re     read enable, loads rdata from addr at the clock edge
//   addr   word address
//   wdata  write data
//   rdata  registered read data, holds between reads
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WordWidth-1:0]  wdata,
    output logic [WordWidth-1:0]  rdata
);

    logic [WordWidth-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_resp.sv
// mem_resp: multi-cycle data-memory responder for the pipeline MEM stage.
//   clk      rising-edge clock
//   rst_n    async active-low reset
//   memRd    read request, held by the pipeline until completion
//   memWr    write request, held by the pipeline until completion (wins over memRd)
//   memAddr  word address; upper bits beyond DEPTH_LOG2 are dropped (aliasing)
//   wrData   store data, sampled at acceptance
//   rdData   registered read data, holds its value outside rdValid
//   rdValid  one-cycle pulse in the completion cycle of a read
//   stall    freezes the pipeline enables while an access is outstanding
// Build option: MEM_POSTED_WR_EN makes writes posted (accepted with stall low and
// drained from a one-entry buffer); any request arriving during the drain stalls.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2,
    parameter int unsigned LATENCY    = DefaultLatency
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 memRd,
    input  logic                 memWr,
    input  logic [15:0]          memAddr,
    input  logic [WordWidth-1:0] wrData,
    output logic [WordWidth-1:0] rdData,
    output logic                 rdValid,
    output logic                 stall
);

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [WordWidth-1:0]  wdata_q;
    logic                  op_wr_q;
    logic                  rd_valid_q;

    logic                  req;
    logic                  accept;
    logic                  complete;
    logic                  cur_wr;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [WordWidth-1:0]  ram_wdata;
    logic                  stall_raw;
    logic                  unused_addr;

    assign unused_addr = ^memAddr[15:DEPTH_LOG2];

    assign req    = memRd | memWr;
    assign accept = (state_q == StIdle) && req;

    // The accepting cycle counts as the first latency cycle, so the access fires on the
    // edge ending cycle LATENCY-1: directly from IDLE when LATENCY is 1, otherwise when
    // the busy counter reaches 1.
    assign complete = (accept && (LATENCY == 1)) || ((state_q == StBusy) && (cnt_q == 4'd1));

    // With LATENCY 1 the access happens on the accepting edge, before the latches load.
    always_comb begin
        cur_wr    = op_wr_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (state_q == StIdle) begin
            cur_wr    = memWr;
            ram_addr  = memAddr[DEPTH_LOG2-1:0];
            ram_wdata = wrData;
        end
    end

    mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (complete & cur_wr),
        .re   (complete & ~cur_wr),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(rdData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_wr_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q  <= memAddr[DEPTH_LOG2-1:0];
                        wdata_q <= wrData;
                        op_wr_q <= memWr;
                        cnt_q   <= CntWidth'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q    <= StDone;
                            rd_valid_q <= ~memWr;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd1) begin
                        state_q    <= StDone;
                        rd_valid_q <= ~op_wr_q;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    // Requests seen here still belong to the completed instruction.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rdValid = rd_valid_q;

`ifdef MEM_POSTED_WR_EN
    // A draining posted write only stalls requests that arrive behind it; a read in
    // flight stalls through BUSY and releases in DONE.
    always_comb begin
        stall_raw = 1'b0;
        unique case (state_q)
            StIdle:  stall_raw = memRd & ~memWr;
            StBusy:  stall_raw = ~op_wr_q | req;
            StDone:  stall_raw = op_wr_q & req;
            default: stall_raw = 1'b0;
        endcase
    end
`else
    always_comb begin
        stall_raw = ((state_q == StIdle) && req) || (state_q == StBusy);
    end
`endif

    // Stall must read low while reset is held, even with a request pending.
    assign stall = rst_n & stall_raw;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: self-checking bench for mem_resp (table vectors, corner sequences,
// randomized transactions against a word-map reference model).
module tb_mem_resp;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DL2   = 10;
    localparam int unsigned DEPTH = 1 << DL2;
`ifdef MEM_POSTED_WR_EN
    localparam bit Posted = 1'b1;
`else
    localparam bit Posted = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRd;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] wrData;
    logic [15:0] rdData;
    logic        rdValid;
    logic        stall;

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;

    logic [15:0]  model_mem [int unsigned];
    int unsigned  keys[$];
    logic [15:0]  last_rd;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[9];

    mem_resp #(
        .DEPTH_LOG2(DL2),
        .LATENCY   (LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .memRd  (memRd),
        .memWr  (memWr),
        .memAddr(memAddr),
        .wrData (wrData),
        .rdData (rdData),
        .rdValid(rdValid),
        .stall  (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Drive one cycle's request at the falling edge, then let outputs settle.
    task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d);
        @(negedge clk);
        memRd   = rd;
        memWr   = wr;
        memAddr = a;
        wrData  = d;
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("idle_stall", stall, 0);
        chk("idle_rdvalid", rdValid, 0);
    endtask

    // One pipeline access held until stall drops; checks latency and the rdValid rule.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] got, output int t_done);
        int k;
        drive(rd, wr, a, d);
        if (Posted && wr) begin
            chk("posted_wr_stall", stall, 0);
            chk("posted_wr_rdvalid", rdValid, 0);
            got    = rdData;
            t_done = cycle;
            for (int i = 0; i < int'(LAT); i++) begin
                drive(1'b0, 1'b0, 16'h0000, 16'h0000);
                chk("posted_drain_stall", stall, 0);
                chk("posted_drain_rdvalid", rdValid, 0);
            end
            return;
        end
        k = 0;
        while (stall === 1'b1 && k < 40) begin
            chk("rdvalid_during_stall", rdValid, 0);
            drive(rd, wr, a, d);
            k++;
        end
        chk("stall_cycles", k, LAT);
        chk("rdvalid_at_done", rdValid, {31'b0, rd & ~wr});
        got    = rdData;
        t_done = cycle;
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] got2;
        int          t1;
        int          t2;
        int          k;

        tbl[0] = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b1, 16'h0405, 16'h1234, 16'hBEEF};
        tbl[3] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234};
        tbl[4] = '{1'b1, 1'b1, 16'h0020, 16'h7777, 16'h1234};
        tbl[5] = '{1'b1, 1'b0, 16'h0420, 16'h0000, 16'h7777};
        tbl[6] = '{1'b0, 1'b1, 16'h0001, 16'h0001, 16'h7777};
        tbl[7] = '{1'b0, 1'b1, 16'h0002, 16'h0002, 16'h7777};
        tbl[8] = '{1'b1, 1'b0, 16'hFC12, 16'h0000, 16'hBEEF};

        // Reset held with a read pending: nothing may leak out.
        rst_n   = 1'b0;
        memRd   = 1'b1;
        memWr   = 1'b0;
        memAddr = 16'h0040;
        wrData  = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_rdvalid", rdValid, 0);
        chk("rst_rddata", rdData, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_accept_stall", stall, 1);
        @(negedge clk);
        #1;
        chk("release_busy_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", stall, 0);
        chk("abort_rdvalid", rdValid, 0);
        @(negedge clk);
        memRd = 1'b0;
        rst_n = 1'b1;
        #1;
        idle_cycle();

        for (int i = 0; i < 9; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, got, t1);
            chk($sformatf("tbl%0d_rddata", i), got, tbl[i].exp);
            idle_cycle();
        end

        // Back-to-back held reads: pulses exactly LAT+1 apart, no re-accept in DONE.
        access(1'b1, 1'b0, 16'h0001, 16'h0000, got, t1);
        access(1'b1, 1'b0, 16'h0002, 16'h0000, got2, t2);
        chk("b2b_rd1_data", got, 16'h0001);
        chk("b2b_rd2_data", got2, 16'h0002);
        chk("b2b_spacing", t2 - t1, LAT + 1);
        idle_cycle();

        // Reset during BUSY cycle 2 of a write must drop the write.
        access(1'b0, 1'b1, 16'h0030, 16'h5555, got, t1);
        idle_cycle();
        drive(1'b0, 1'b1, 16'h0030, 16'hAAAA);
        drive(1'b0, 1'b1, 16'h0030, 16'hAAAA);
        drive(1'b0, 1'b1, 16'h0030, 16'hAAAA);
        rst_n = 1'b0;
        #1;
        chk("midbusy_rst_stall", stall, 0);
        chk("midbusy_rst_rddata", rdData, 0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        idle_cycle();
        access(1'b1, 1'b0, 16'h0030, 16'h0000, got, t1);
        chk("midbusy_write_dropped", got, 16'h5555);
        idle_cycle();

`ifdef MEM_POSTED_WR_EN
        // Posted write then an immediate read of the same word.
        drive(1'b0, 1'b1, 16'h0007, 16'h00FF);
        chk("posted_cycle0_stall", stall, 0);
        drive(1'b1, 1'b0, 16'h0007, 16'h0000);
        k = 0;
        while (stall === 1'b1 && k < 40) begin
            drive(1'b1, 1'b0, 16'h0007, 16'h0000);
            k++;
        end
        chk("posted_raw_stall_cycles", k, 2 * LAT);
        chk("posted_raw_rdvalid", rdValid, 1);
        chk("posted_raw_rddata", rdData, 16'h00FF);
        idle_cycle();
        last_rd = 16'h00FF;
`else
        last_rd = 16'h5555;
`endif

        // Randomized traffic against a word-map model with aliased addresses.
        for (int n = 0; n < 60; n++) begin
            logic        do_wr;
            logic        rd_bit;
            int unsigned key;
            logic [15:0] a;
            logic [15:0] d;
            do_wr  = (keys.size() == 0) || ($urandom_range(0, 1) == 1);
            rd_bit = do_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (do_wr) begin
                key = $urandom_range(0, 15) * 37;
            end else begin
                key = keys[$urandom_range(0, keys.size() - 1)];
            end
            a = 16'(key + DEPTH * $urandom_range(0, 63));
            d = 16'($urandom);
            access(rd_bit, do_wr, a, d, got, t1);
            if (do_wr) begin
                if (!model_mem.exists(key)) keys.push_back(key);
                model_mem[key] = d;
            end else begin
                last_rd = model_mem[key];
            end
            chk($sformatf("rand%0d_rddata", n), got, last_rd);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
